// File: rtl/vote_input_conditioner.sv
// rtl/vote_input_conditioner.sv - debounced, one-vote-per-press candidate button conditioner
module vote_input_conditioner #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  output logic [3:0] vote_pulse,
  output logic       multi_press_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, QUALIFY, FIRE, WAIT_RELEASE} state_t;

  localparam logic [7:0] HOLD = 8'(HOLD_CYCLES);

  logic [3:0] sync1_q, btn_s;
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] sel_q, sel_d;
  logic       rel_q, rel_d;
  logic       blk_q, blk_d;
  logic [3:0] vote_q, vote_d;
  logic       err_q, err_d;
  logic       btn_onehot, btn_multi, btn_none;

  assign btn_onehot = $onehot(btn_s);
  assign btn_none   = (btn_s == 4'b0000);
  assign btn_multi  = !btn_none && !btn_onehot;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rel_d   = rel_q;
    vote_d  = 4'b0000;
    err_d   = 1'b0;
    // A button held across result mode must be released before it can vote.
    blk_d   = !btn_none && (blk_q || mode);
    case (state_q)
      IDLE: begin
        if (!mode && !blk_q) begin
          if (btn_onehot) begin
            sel_d   = btn_s;
            cnt_d   = 8'd1;
            state_d = QUALIFY;
          end else if (btn_multi) begin
            err_d   = 1'b1;
            rel_d   = 1'b0;
            state_d = WAIT_RELEASE;
          end
        end
      end
      QUALIFY: begin
        if (btn_none) begin
          state_d = IDLE;
        end else if (mode) begin
          rel_d   = 1'b0;
          state_d = WAIT_RELEASE;
        end else if (btn_s != sel_q) begin
          err_d   = 1'b1;
          rel_d   = 1'b0;
          state_d = WAIT_RELEASE;
        end else begin
          if (cnt_q < HOLD) cnt_d = cnt_q + 8'd1;
          // Pulse is registered on the entry into FIRE so it is high exactly while in FIRE.
          if (cnt_q + 8'd1 >= HOLD) begin
            vote_d  = sel_q;
            state_d = FIRE;
          end
        end
      end
      FIRE: begin
        rel_d   = 1'b0;
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (btn_none) begin
          if (rel_q) state_d = IDLE;
          rel_d = 1'b1;
        end else begin
          rel_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 4'b0000;
      btn_s   <= 4'b0000;
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      sel_q   <= 4'b0000;
      rel_q   <= 1'b0;
      blk_q   <= 1'b0;
      vote_q  <= 4'b0000;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= {button4, button3, button2, button1};
      btn_s   <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rel_q   <= rel_d;
      blk_q   <= blk_d;
      vote_q  <= vote_d;
      err_q   <= err_d;
    end
  end

  assign vote_pulse      = vote_q;
  assign multi_press_err = err_q;
  assign busy            = (state_q != IDLE);

endmodule
